// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the AXI4-Lite load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_MIS = 2'b01,
    ERR_BUS = 2'b10,
    ERR_TMO = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef struct packed {
    logic       wen;
    logic [1:0] size;
    logic       zext;
  } req_ctl_t;

  function automatic logic is_misaligned(
    input logic [2:0] lo,
    input logic [1:0] size,
    input logic       dw64
  );
    logic m;
    unique case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = lo[0];
      SZ_W:    m = |lo[1:0];
      default: m = !dw64 || (|lo);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane extract/extend for loads, shift/strobe for
// stores.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          size,
  input  logic [OFS_W-1:0]    ofs,
  input  logic                zext,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic [DATA_W-1:0]   st_wdata,
  output logic [DATA_W-1:0]   ld_data,
  output logic [DATA_W-1:0]   st_data,
  output logic [DATA_W/8-1:0] st_strb
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] up;
  logic [7:0]        nbits;
  logic [7:0]        sft;
  logic [BYTES-1:0]  mask;

  // Left-justify the field, then shift back logically or arithmetically.
  always_comb begin
    nbits = 8'd8 << size;
    sft = (nbits >= 8'(DATA_W)) ? 8'd0 : 8'(DATA_W) - nbits;
    sh = bus_rdata >> {ofs, 3'b000};
    up = sh << sft;
    if (zext) ld_data = up >> sft;
    else ld_data = $unsigned($signed(up) >>> sft);
    mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      mask[i] = (i < (1 << size));
    end
    st_strb = mask << ofs;
    st_data = st_wdata << {ofs, 3'b000};
  end

endmodule

// File: rtl/lsu_axi.sv
// lsu_axi: single-outstanding AXI4-Lite load/store unit.
// Define LSU_TIMEOUT_EN to enable the TIMEOUT_CYC watchdog.
module lsu_axi
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int BYTES      = DATA_W / 8,
  localparam int OFS_W      = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [BYTES-1:0]  wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t            state;
  state_t            nxt;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        err_q;
  logic              aw_done;
  logic              w_done;
  logic              mis;
  logic              accept;
  logic              tmo;
  logic [DATA_W-1:0] ld_data;

  assign mis    = is_misaligned(req_addr[2:0], req_size, DATA_W == 64);
  assign accept = (state == S_IDLE) && req_valid;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             busy;

  assign busy = state inside {S_AR, S_R, S_AW_W, S_B};
  assign tmo  = busy && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (!busy) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (mis) nxt = S_RESP;
          else if (req_wen) nxt = S_AW_W;
          else nxt = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) nxt = S_RESP;
      end
      S_AW_W: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if (aw_done && w_done) nxt = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (tmo) nxt = S_RESP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (accept) begin
        ctl_q   <= '{wen: req_wen, size: req_size,
                     zext: req_unsigned};
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= mis ? ERR_MIS : ERR_OK;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready) w_done <= 1'b1;
      if (rready && rvalid) begin
        rdata_q <= (|rresp) ? '0 : ld_data;
        err_q   <= (|rresp) ? ERR_BUS : ERR_OK;
      end
      if (bready && bvalid && |bresp) err_q <= ERR_BUS;
      // A watchdog expiry overrides any response landing the same cycle.
      if (tmo) begin
        rdata_q <= '0;
        err_q   <= ERR_TMO;
      end
    end
  end

  assign araddr    = {addr_q[ADDR_W-1:OFS_W], OFS_W'(0)};
  assign awaddr    = {addr_q[ADDR_W-1:OFS_W], OFS_W'(0)};
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size      (ctl_q.size),
    .ofs       (addr_q[OFS_W-1:0]),
    .zext      (ctl_q.zext),
    .bus_rdata (rdata),
    .st_wdata  (wdata_q),
    .ld_data   (ld_data),
    .st_data   (wdata),
    .st_strb   (wstrb)
  );

endmodule

// File: tb/tb_lsu_axi.sv
// tb_lsu_axi: directed checks of lsu_axi at DATA_W=32 and DATA_W=64.
module tb_lsu_axi;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  logic        req_valid6, req_ready6, req_wen6, req_unsigned6;
  logic [31:0] req_addr6, araddr6, awaddr6;
  logic [63:0] req_wdata6, rsp_rdata6, rdata6, wdata6;
  logic [1:0]  req_size6, rsp_err6, rresp6, bresp6;
  logic        rsp_valid6, arvalid6, arready6, rvalid6, rready6;
  logic        awvalid6, awready6, wvalid6, wready6, bvalid6, bready6;
  logic [7:0]  wstrb6;

  int n_chk = 0;
  int n_fail = 0;

  int          lat, arv_n, awv_n, wv_n, bhs_n;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_err;

  lsu_axi #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  lsu_axi #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid6), .req_ready(req_ready6),
    .req_wen(req_wen6), .req_addr(req_addr6),
    .req_wdata(req_wdata6), .req_size(req_size6),
    .req_unsigned(req_unsigned6),
    .rsp_valid(rsp_valid6), .rsp_rdata(rsp_rdata6),
    .rsp_err(rsp_err6),
    .araddr(araddr6), .arvalid(arvalid6), .arready(arready6),
    .rdata(rdata6), .rresp(rresp6), .rvalid(rvalid6),
    .rready(rready6),
    .awaddr(awaddr6), .awvalid(awvalid6), .awready(awready6),
    .wdata(wdata6), .wstrb(wstrb6), .wvalid(wvalid6),
    .wready(wready6),
    .bresp(bresp6), .bvalid(bvalid6), .bready(bready6)
  );

  // Issue one request and watch the bus until rsp_valid or max_cyc.
  task automatic xact(input logic wen, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [1:0] size,
                      input logic zx, input int aw_delay,
                      input int max_cyc);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen = wen;
    req_addr = addr;
    req_wdata = wd;
    req_size = size;
    req_unsigned = zx;
    awready = (aw_delay == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; arv_n = 0; awv_n = 0; wv_n = 0; bhs_n = 0;
    m_araddr = 'x; m_awaddr = 'x; m_wdata = 'x; m_wstrb = 'x;
    m_rdata = 'x; m_err = 'x;
    for (int c = 1; c <= max_cyc && lat == 0; c++) begin
      @(negedge clk);
      if (arvalid) begin arv_n++; m_araddr = araddr; end
      if (awvalid) begin awv_n++; m_awaddr = awaddr; end
      if (wvalid) begin
        wv_n++; m_wdata = wdata; m_wstrb = wstrb;
      end
      if (bvalid && bready) bhs_n++;
      if (rsp_valid) begin
        lat = c; m_rdata = rsp_rdata; m_err = rsp_err;
      end
      awready = (c > aw_delay);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_chk++;
    if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid}
        !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b exp 000000",
               {arvalid, rready, awvalid, wvalid, bready, rsp_valid});
    end
    n_chk++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h/%b exp 0/00",
               rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b exp 1", req_ready);
    end
  endtask

  task automatic test_load();
    rdata = 32'h80AA_BBCC;
    xact(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 0, 10);
    n_chk++;
    if (m_araddr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL lb_araddr: got %h exp 80000000", m_araddr);
    end
    n_chk++;
    if (m_rdata !== 32'hFFFF_FF80 || m_err !== 2'b00) begin
      n_fail++;
      $display("FAIL lb_data: got %h/%b exp ffffff80/00",
               m_rdata, m_err);
    end
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL lb_latency: got %0d exp 3", lat);
    end
    xact(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 0, 10);
    n_chk++;
    if (m_rdata !== 32'h0000_0080 || m_err !== 2'b00) begin
      n_fail++;
      $display("FAIL lbu_data: got %h/%b exp 00000080/00",
               m_rdata, m_err);
    end
    xact(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 0, 10);
    n_chk++;
    if (m_rdata !== 32'hFFFF_80AA) begin
      n_fail++;
      $display("FAIL lh_data: got %h exp ffff80aa", m_rdata);
    end
  endtask

  task automatic test_store();
    xact(1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0, 0, 10);
    n_chk++;
    if (m_awaddr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sh_awaddr: got %h exp 80000000", m_awaddr);
    end
    n_chk++;
    if (m_wdata !== 32'h1234_0000 || m_wstrb !== 4'b1100) begin
      n_fail++;
      $display("FAIL sh_wdata: got %h/%b exp 12340000/1100",
               m_wdata, m_wstrb);
    end
    n_chk++;
    if (m_err !== 2'b00 || m_rdata !== 32'h0 || lat !== 4) begin
      n_fail++;
      $display("FAIL sh_rsp: got %b/%h/%0d exp 00/0/4",
               m_err, m_rdata, lat);
    end
  endtask

  task automatic test_misaligned();
    xact(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 0, 10);
    n_chk++;
    if (arv_n !== 0 || awv_n !== 0) begin
      n_fail++;
      $display("FAIL mis_bus: got ar=%0d aw=%0d exp 0/0",
               arv_n, awv_n);
    end
    n_chk++;
    if (m_err !== 2'b01 || lat !== 1) begin
      n_fail++;
      $display("FAIL mis_lw: got %b/%0d exp 01/1", m_err, lat);
    end
    xact(1'b1, 32'h0000_0000, 32'h0, 2'd3, 1'b0, 0, 10);
    n_chk++;
    if (m_err !== 2'b01 || lat !== 1 || awv_n !== 0) begin
      n_fail++;
      $display("FAIL mis_sd32: got %b/%0d/%0d exp 01/1/0",
               m_err, lat, awv_n);
    end
  endtask

  task automatic test_aw_delay();
    xact(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 2'd2, 1'b0, 3, 20);
    n_chk++;
    if (wv_n !== 1 || awv_n !== 4) begin
      n_fail++;
      $display("FAIL awdly_valids: got w=%0d aw=%0d exp 1/4",
               wv_n, awv_n);
    end
    n_chk++;
    if (bhs_n !== 1 || m_err !== 2'b00 || lat !== 7) begin
      n_fail++;
      $display("FAIL awdly_rsp: got b=%0d %b lat=%0d exp 1/00/7",
               bhs_n, m_err, lat);
    end
    n_chk++;
    if (m_wdata !== 32'hCAFE_F00D || m_wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL awdly_wdata: got %h/%h exp cafef00d/f",
               m_wdata, m_wstrb);
    end
  endtask

  task automatic test_bus_err();
    rresp = 2'b10;
    rdata = 32'hDEAD_BEEF;
    xact(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 0, 10);
    rresp = 2'b00;
    n_chk++;
    if (m_err !== 2'b10 || m_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rresp_err: got %b/%h exp 10/0", m_err, m_rdata);
    end
    bresp = 2'b10;
    xact(1'b1, 32'h8000_0001, 32'h0000_00FF, 2'd0, 1'b0, 0, 10);
    bresp = 2'b00;
    n_chk++;
    if (m_err !== 2'b10 || m_wdata !== 32'h0000_FF00
        || m_wstrb !== 4'b0010 || lat !== 4) begin
      n_fail++;
      $display("FAIL bresp_err: got %b/%h/%b/%0d exp 10/ff00/0010/4",
               m_err, m_wdata, m_wstrb, lat);
    end
  endtask

  task automatic test_rst_mid();
    rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0;
    req_addr = 32'h8000_0000; req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (rready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_in_r: got rready=%b exp 1", rready);
    end
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if ({rready, arvalid, rsp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got %b exp 000",
               {rready, arvalid, rsp_valid});
    end
    @(negedge clk);
    rst = 1'b1;
    rvalid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %b exp 1", req_ready);
    end
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || rready !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rsp_idle: got %b%b exp 00",
               rsp_valid, rready);
    end
  endtask

  task automatic test_wide64();
    logic [31:0] addr [2];
    logic [1:0]  sz [2];
    logic [63:0] exp [2];
    int          l6;
    logic [31:0] a6;
    logic [63:0] d6;
    addr[0] = 32'h8; sz[0] = 2'd3; exp[0] = 64'h1122_3344_5566_7788;
    addr[1] = 32'hC; sz[1] = 2'd2; exp[1] = 64'h0000_0000_1122_3344;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      req_valid6 = 1'b1; req_addr6 = addr[v]; req_size6 = sz[v];
      @(posedge clk);
      #1 req_valid6 = 1'b0;
      l6 = 0; a6 = 'x; d6 = 'x;
      for (int c = 1; c <= 10 && l6 == 0; c++) begin
        @(negedge clk);
        if (arvalid6) a6 = araddr6;
        if (rsp_valid6) begin l6 = c; d6 = rsp_rdata6; end
      end
      n_chk++;
      if (d6 !== exp[v] || a6 !== 32'h8 || l6 !== 3) begin
        n_fail++;
        $display("FAIL wide64_%0d: got %h/%h/%0d exp %h/8/3",
                 v, d6, a6, l6, exp[v]);
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    arready = 1'b0;
    xact(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0, 400);
    arready = 1'b1;
    n_chk++;
    if (m_err !== 2'b11 || lat !== 256 || m_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout: got %b/%0d/%h exp 11/256/0",
               m_err, lat, m_rdata);
    end
  endtask
`endif

  initial begin
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
    req_size = 0; req_unsigned = 0;
    arready = 1; rvalid = 1; rdata = 0; rresp = 0;
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    req_valid6 = 0; req_wen6 = 0; req_addr6 = 0; req_wdata6 = 0;
    req_size6 = 0; req_unsigned6 = 0;
    arready6 = 1; rvalid6 = 1; rdata6 = 64'h1122_3344_5566_7788;
    rresp6 = 0; awready6 = 1; wready6 = 1; bvalid6 = 1; bresp6 = 0;
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_aw_delay();
    test_bus_err();
    test_rst_mid();
    test_wide64();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_axi.md
Name:
lsu_axi

Overview:
Parametrised load/store unit. It takes one load or store request at a time from the execute stage and runs it as a single AXI4-Lite master transaction. It also performs byte-lane alignment, strobe generation and sign/zero extension, and reports misaligned-access, bus-error and timeout status. It sits between EXU and the data-side crossbar and replaces the fixed 32-bit LSU.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, bus and register width; legal values 32 or 64; BYTES=DATA_W/8, OFS_W=log2(BYTES).
TIMEOUT_CYC, 255, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-low.
req_valid/req_ready  in/out  1/1  request handshake.
req_wen  in  1  1=store, 0=load.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, LSB-justified.
req_size  in  2  access size: 0=B, 1=H, 2=W, 3=D.
req_unsigned  in  1  zero-extend load.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
rsp_err  out  2  00 ok, 01 misaligned, 10 bus error, 11 timeout.
araddr, arvalid / arready  out / in  ADDR_W, 1 / 1  AR channel.
rdata, rresp, rvalid / rready  in / out  DATA_W, 2, 1 / 1  R channel.
awaddr, awvalid / awready  out / in  ADDR_W, 1 / 1  AW channel.
wdata, wstrb, wvalid / wready  out / in  DATA_W, BYTES, 1 / 1  W channel.
bresp, bvalid / bready  in / out  2, 1 / 1  B channel.

Behaviour:
- States: IDLE, AR, R, AW_W, B, RESP. Reset (rst low, asynchronous) forces IDLE, all valid/ready outputs 0, rsp_rdata 0, rsp_err 0.
- req_ready = (state==IDLE). On accept, latch addr, wdata, size, unsigned and wen.
- Misaligned access: addr not a multiple of 2^size, or size 3 when DATA_W=32. Go directly to RESP with err 01; no AXI activity.
- Load path:
  - AR: arvalid held high until arready.
  - araddr = addr with the low OFS_W bits cleared.
  - R: rready=1. On rvalid, extract bytes at offset addr[OFS_W-1:0], extend to DATA_W, and go to RESP.
  - rresp!=0 gives err 10 and rdata 0.
- Store path:
  - AW_W: awvalid and wvalid are raised together. Each drops independently after its own handshake. Move to B once both have completed; simultaneous handshakes are legal.
  - wdata = req_wdata << (8*offset).
  - wstrb = ((1<<2^size)-1) << offset.
  - B: bready=1. On bvalid go to RESP; bresp!=0 gives err 10.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no back-pressure on the response.
- Zero-wait slave latency from accept cycle T: rsp_valid at T+3 for load, T+4 for store, T+1 for misaligned.
- req_valid outside IDLE is ignored. rready and bready are 0 outside R and B.
- Reset mid-transaction abandons the transfer. Late slave responses arriving in IDLE are ignored.

Optional Feature:
LSU_TIMEOUT_EN defined:
- A counter runs in AR/R/AW_W/B and clears on entering IDLE.
- At TIMEOUT_CYC the unit drops all valids, goes to RESP with err 11, and ignores that transaction's late responses.

LSU_TIMEOUT_EN undefined:
- No counter; the unit waits indefinitely.
- err 11 is never produced.

Decomposition:
- lsu_pkg: state enum, rsp_err codes, size codes, and an is_misaligned function.
- Sub-module lsu_lane_align (combinational): load extract/extend and store shift/strobe, parametrised by DATA_W.

Test Plan:
- DATA_W=32, lb from 0x8000_0003, rdata 0x80AA_BBCC, zero-wait slave -> araddr 0x8000_0000, rsp_rdata 0xFFFF_FF80, err 00, rsp_valid at T+3. Same with req_unsigned -> 0x0000_0080.
- sh 0x1234 to 0x8000_0002 -> awaddr 0x8000_0000, wdata 0x1234_0000, wstrb 4'b1100, err 00.
- lw from 0x8000_0002 -> no arvalid/awvalid, rsp_valid at T+1, err 01. DATA_W=32 with size 3 at 0x0 -> err 01.
- Store with wready immediate and awready delayed 3 cycles -> wvalid high 1 cycle, awvalid 4 cycles, exactly one B handshake, rsp ok.
- Load with rresp=2'b10 -> err 10, rsp_rdata 0. DATA_W=64 ld from 0x8 with rdata 0x1122334455667788 -> passed through unchanged.
- rst low while in R -> rready, arvalid and rsp_valid go 0 immediately and req_ready=1 after release. With LSU_TIMEOUT_EN and arready stuck 0 -> err 11 after TIMEOUT_CYC cycles.
